ghr_checkpoint_unit: RTL

- Speculative global-history manager feeding the global/tournament branch predictor.
- Shifts predicted conditional-branch outcomes into a speculative GHR and checkpoints the pre-branch history per in-flight branch in a circular buffer.
- On in-order resolution it updates the committed GHR; on a mispredict it repairs the speculative GHR and discards younger checkpoints.
- Sits between frontend prediction and branch resolution; `ghr_o` is the index/hash history consumed by the predictor.

---
 rtl/ghr_checkpoint_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/ghr_checkpoint_unit.sv
// ghr_checkpoint_unit
// Speculative global-history manager. Predicted conditional-branch outcomes
// are shifted into a speculative history. The pre-branch history of every
// in-flight branch is checkpointed in a circular buffer so that a mispredict
// can restore it. In-order resolutions advance the committed history.

module ghr_checkpoint_unit #(
    parameter  int GHR_LEN = 10,
    parameter  int NR_CKPT = 8,
    localparam int ID_W    = $clog2(NR_CKPT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               predict_valid_i,
    input  logic               predict_taken_i,
    output logic               predict_ready_o,
    output logic [ID_W-1:0]    predict_id_o,
    output logic [GHR_LEN-1:0] ghr_o,
    output logic [GHR_LEN-1:0] committed_ghr_o,
    input  logic               resolve_valid_i,
    input  logic [ID_W-1:0]    resolve_id_i,
    input  logic               resolve_taken_i,
    input  logic               resolve_mispredict_i,
    output logic [ID_W:0]      count_o,
    output logic               id_error_o
);

    localparam logic [ID_W:0] FullCount = (ID_W+1)'(NR_CKPT);

    logic [GHR_LEN-1:0] ckptMem [NR_CKPT];

    logic [GHR_LEN-1:0] specGhr_q,   specGhr_d;
    logic [GHR_LEN-1:0] commitGhr_q, commitGhr_d;
    logic [ID_W-1:0]    head_q,      head_d;
    logic [ID_W-1:0]    tail_q,      tail_d;
    logic [ID_W:0]      count_q,     count_d;
    logic               idError_q,   idError_d;

    logic bufferFull;
    logic resolveOk;
    logic mispredict;
    logic predictAccept;

    // Classify this cycle's requests and compute every next-state value by priority: flush, mispredict, then normal flow
    always_comb begin
        bufferFull    = (count_q == FullCount);
        resolveOk     = resolve_valid_i && (count_q != '0) && (resolve_id_i == head_q);
        mispredict    = resolveOk && resolve_mispredict_i;
        predictAccept = predict_valid_i && !bufferFull && !flush_i && !mispredict;

        specGhr_d   = specGhr_q;
        commitGhr_d = commitGhr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        idError_d   = resolve_valid_i && !resolveOk;

        if (resolveOk) begin
            commitGhr_d = {commitGhr_q[GHR_LEN-2:0], resolve_taken_i};
        end

        if (flush_i) begin
            specGhr_d = commitGhr_d;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else if (mispredict) begin
            specGhr_d = {ckptMem[head_q][GHR_LEN-2:0], resolve_taken_i};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else begin
            if (predictAccept) begin
                specGhr_d = {specGhr_q[GHR_LEN-2:0], predict_taken_i};
                tail_d    = tail_q + ID_W'(1);
            end
            if (resolveOk) begin
                head_d = head_q + ID_W'(1);
            end
            count_d = count_q + (ID_W+1)'(predictAccept) - (ID_W+1)'(resolveOk);
        end
    end

    // Architectural and speculative state; everything clears on reset so no tag survives
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            specGhr_q   <= '0;
            commitGhr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            idError_q   <= 1'b0;
        end else begin
            specGhr_q   <= specGhr_d;
            commitGhr_q <= commitGhr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            idError_q   <= idError_d;
        end
    end

    // Checkpoint storage holds the pre-branch history; contents are only read for live entries, so no reset
    always_ff @(posedge clk_i) begin
        if (predictAccept) begin
            ckptMem[tail_q] <= specGhr_q;
        end
    end

    assign predict_ready_o = !bufferFull;
    assign predict_id_o    = tail_q;
    assign ghr_o           = specGhr_q;
    assign committed_ghr_o = commitGhr_q;
    assign count_o         = count_q;
    assign id_error_o      = idError_q;

endmodule
